inst_encoder_loader: RTL and testbench

- Inverse of the instruction decoder. Accepts instruction fields over a valid/ready stream and packs them into 32-bit instruction words in the same ISA layout.
- Writes each packed word into consecutive instruction-memory locations, starting from a programmable base address.
- Sits between the testbench/boot loader and the instruction memory write port, and runs one load session per start pulse.

---
 rtl/inst_encoder_loader.sv | 143 ++++++++++++++
 tb/tb_inst_encoder_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder_loader.sv
// Purpose : packs R/A-type instruction fields into 32-bit words and writes them to
//           consecutive instruction-memory addresses, one load session per start.
// Latency : one cycle from an accepted field transfer to the registered memory write.
// Backpressure: in_ready is high for the whole LOAD state and never depends on in_valid.
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   start, base_addr, num_insts session control, sampled only in IDLE
//   in_valid/in_ready, in_*     instruction field stream
//   mem_we, mem_addr, mem_wdata instruction-memory write port (registered)
//   busy, done, err_range       status: in LOAD, completion pulse, sticky address overflow
module inst_encoder_loader #(
   parameter int ADDR_W = 15,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  num_insts,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_fmt,
   input  logic [2:0]        in_opcode,
   input  logic [4:0]        in_reg0,
   input  logic [4:0]        in_reg1,
   input  logic [4:0]        in_reg2,
   input  logic [14:0]       in_addr,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err_range
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ZERO = '0;

   state_t              r_state;
   state_t              w_next;
   logic [ADDR_W-1:0]   r_cur_addr;
   logic [CNT_W-1:0]    r_remaining;
   logic                r_err_range;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [31:0]         r_mem_wdata;

   logic                w_start_ok;
   logic                w_xfer;
   logic                w_last;
   logic                w_wrap;
   logic [31:0]         w_word;

   // Bit 14 belongs to reg2 (R-type) or addr (A-type); the format alone chooses.
   always_comb begin
      w_word = '0;
      if (in_fmt) begin
         w_word = {in_opcode, in_reg0, in_reg1, 4'b0000, in_addr};
      end else begin
         w_word = {in_opcode, in_reg0, in_reg1, in_reg2, 14'b0};
      end
   end

   // Next state; the status outputs decode straight from the state register.
   always_comb begin
      w_next     = r_state;
      w_start_ok = 1'b0;
      w_xfer     = 1'b0;
      w_last     = 1'b0;
      w_wrap     = 1'b0;
      in_ready   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_start_ok = 1'b1;
               w_next     = (num_insts == CNT_ZERO) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            w_xfer   = in_valid;
            w_last   = (r_remaining == CNT_ONE);
            // Top of the address space with more words pending: stop rather than wrap.
            w_wrap   = (&r_cur_addr) && (r_remaining > CNT_ONE);
            if (w_xfer && (w_last || w_wrap)) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cur_addr  <= '0;
         r_remaining <= '0;
         r_err_range <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_state  <= w_next;
         r_mem_we <= w_xfer;
         if (w_start_ok) begin
            r_cur_addr  <= base_addr;
            r_remaining <= num_insts;
            r_err_range <= 1'b0;
         end
         if (w_xfer) begin
            r_mem_addr  <= r_cur_addr;
            r_mem_wdata <= w_word;
            r_cur_addr  <= r_cur_addr + ADDR_ONE;
            r_remaining <= r_remaining - CNT_ONE;
            if (w_wrap) begin
               r_err_range <= 1'b1;
            end
         end
      end
   end

   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign err_range = r_err_range;

endmodule

// File: tb/tb_inst_encoder_loader.sv
module tb_inst_encoder_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [14:0] base_addr;
   logic [15:0] num_insts;
   logic        in_valid;
   logic        in_ready;
   logic        in_fmt;
   logic [2:0]  in_opcode;
   logic [4:0]  in_reg0, in_reg1, in_reg2;
   logic [14:0] in_addr;
   logic        mem_we;
   logic [14:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        busy, done, err_range;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   inst_encoder_loader #(.ADDR_W(15), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_insts(num_insts),
      .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
      .in_reg0(in_reg0), .in_reg1(in_reg1), .in_reg2(in_reg2), .in_addr(in_addr),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .err_range(err_range)
   );

   // Writes to address 0 after a wrap must never happen; watched continuously.
   logic wrap_session = 1'b0;
   int   bad_wrap_writes = 0;
   always @(negedge clk) begin
      if (wrap_session && mem_we && mem_addr == 15'h0000) bad_wrap_writes++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs driven and outputs sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fields(input logic f, input logic [2:0] op, input logic [4:0] r0,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [14:0] a);
      in_fmt = f; in_opcode = op; in_reg0 = r0; in_reg1 = r1; in_reg2 = r2; in_addr = a;
   endtask

   task automatic begin_session(input logic [14:0] b, input logic [15:0] n);
      start = 1'b1; base_addr = b; num_insts = n;
      tick();
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; num_insts = '0; in_valid = 1'b0;
      fields(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 15'd0);
      tick(); tick();
      rst = 1'b0;
      // Reset state
      chk("rst_in_ready", in_ready, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err_range, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);

      // R-type encode, in_addr ignored
      begin_session(15'h0010, 16'd1);
      chk("r_busy", busy, 1);
      chk("r_in_ready", in_ready, 1);
      chk("r_we_before", mem_we, 0);
      fields(1'b0, 3'b101, 5'd3, 5'd7, 5'd31, 15'h7FFF);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("r_we", mem_we, 1);
      chk("r_addr", mem_addr, 32'h0010);
      chk("r_wdata", mem_wdata, 32'hA33FC000);
      chk("r_done", done, 1);
      chk("r_busy_after", busy, 0);
      chk("r_ready_after", in_ready, 0);
      tick();
      chk("r_we_idle", mem_we, 0);
      chk("r_done_idle", done, 0);

      // A-type encode, reg2 ignored
      begin_session(15'h0000, 16'd1);
      fields(1'b1, 3'b010, 5'd1, 5'd2, 5'd31, 15'h1234);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("a_we", mem_we, 1);
      chk("a_addr", mem_addr, 32'h0000);
      chk("a_wdata", mem_wdata, 32'h41101234);
      chk("a_done", done, 1);
      tick();

      // Multi-word with gaps: valid pattern 1,0,0,1,1
      begin_session(15'h0100, 16'd3);
      fields(1'b1, 3'd7, 5'd31, 5'd31, 5'd0, 15'h7FFF);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("m0_we", mem_we, 1);
      chk("m0_addr", mem_addr, 32'h0100);
      chk("m0_wdata", mem_wdata, 32'hFFF87FFF);
      tick();
      chk("m_gap1_we", mem_we, 0);
      chk("m_gap1_ready", in_ready, 1);
      tick();
      chk("m_gap2_we", mem_we, 0);
      fields(1'b0, 3'd0, 5'd1, 5'd2, 5'd3, 15'h7FFF);
      in_valid = 1'b1;
      tick();
      chk("m1_we", mem_we, 1);
      chk("m1_addr", mem_addr, 32'h0101);
      chk("m1_wdata", mem_wdata, 32'h0110C000);
      chk("m1_done", done, 0);
      fields(1'b1, 3'd1, 5'd0, 5'd0, 5'd31, 15'h4000);
      tick();
      in_valid = 1'b0;
      chk("m2_we", mem_we, 1);
      chk("m2_addr", mem_addr, 32'h0102);
      chk("m2_wdata", mem_wdata, 32'h20004000);
      chk("m2_done", done, 1);
      chk("m2_ready", in_ready, 0);
      tick();
      chk("m_after_ready", in_ready, 0);
      chk("m_after_we", mem_we, 0);

      // Range wrap: only 0x7FFE and 0x7FFF written
      wrap_session = 1'b1;
      begin_session(15'h7FFE, 16'd4);
      fields(1'b0, 3'd2, 5'd4, 5'd5, 5'd6, 15'd0);
      in_valid = 1'b1;
      tick();
      chk("w0_addr", mem_addr, 32'h7FFE);
      chk("w0_err", err_range, 0);
      chk("w0_done", done, 0);
      tick();
      chk("w1_we", mem_we, 1);
      chk("w1_addr", mem_addr, 32'h7FFF);
      chk("w1_done", done, 1);
      chk("w1_err", err_range, 1);
      tick();
      chk("w_post_we", mem_we, 0);
      chk("w_post_busy", busy, 0);
      chk("w_err_sticky", err_range, 1);
      tick();
      in_valid = 1'b0;
      chk("w_idle_we", mem_we, 0);
      chk("w_err_sticky2", err_range, 1);
      wrap_session = 1'b0;
      chk("w_no_addr0_write", bad_wrap_writes, 0);

      // Zero count: done the cycle after start, no writes; err cleared by start
      begin_session(15'h0300, 16'd0);
      chk("z_err_clear", err_range, 0);
      chk("z_done", done, 1);
      chk("z_we", mem_we, 0);
      chk("z_busy", busy, 0);
      tick();
      chk("z_done_off", done, 0);
      chk("z_we_off", mem_we, 0);

      // Start during LOAD is ignored
      begin_session(15'h0400, 16'd2);
      start = 1'b1; base_addr = 15'h0555; num_insts = 16'd9;
      tick();
      start = 1'b0;
      fields(1'b0, 3'd3, 5'd1, 5'd1, 5'd1, 15'd0);
      in_valid = 1'b1;
      tick();
      chk("i0_addr", mem_addr, 32'h0400);
      chk("i0_done", done, 0);
      tick();
      in_valid = 1'b0;
      chk("i1_addr", mem_addr, 32'h0401);
      chk("i1_done", done, 1);
      tick();

      // Reset mid-load
      begin_session(15'h0500, 16'd5);
      in_valid = 1'b1;
      tick();
      tick();
      chk("rm1_addr", mem_addr, 32'h0501);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      chk("rm_we", mem_we, 0);
      chk("rm_busy", busy, 0);
      chk("rm_ready", in_ready, 0);
      chk("rm_done", done, 0);
      tick();
      chk("rm_done2", done, 0);
      begin_session(15'h0200, 16'd1);
      chk("rs_busy", busy, 1);
      fields(1'b1, 3'd6, 5'd2, 5'd3, 5'd0, 15'h0001);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("rs_we", mem_we, 1);
      chk("rs_addr", mem_addr, 32'h0200);
      chk("rs_wdata", mem_wdata, 32'hC2180001);
      chk("rs_done", done, 1);
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
